// File: rtl/banyan_pkg.sv
// banyan_pkg: shared mode encodings and helpers for the buffered banyan switching element
package banyan_pkg;
    localparam logic [1:0] MODE_SELF     = 2'b00;
    localparam logic [1:0] MODE_STRAIGHT = 2'b01;
    localparam logic [1:0] MODE_CROSS    = 2'b10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/banyan_se2x2_buf_if.sv
// banyan_se2x2_buf_if: handshake bundle of the 2x2 switching element
// Ports: mode, inN_valid/data/dest/ready, outN_valid/data/dest/ready, conflict_cnt
interface banyan_se2x2_buf_if #(
    parameter int DATA_W = 8,
    parameter int DEST_W = 2,
    parameter int CNT_W  = 16
);
    logic [1:0]        mode;
    logic              in0_valid, in1_valid, in0_ready, in1_ready;
    logic [DATA_W-1:0] in0_data, in1_data, out0_data, out1_data;
    logic [DEST_W-1:0] in0_dest, in1_dest, out0_dest, out1_dest;
    logic              out0_valid, out1_valid, out0_ready, out1_ready;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output mode, in0_valid, in0_data, in0_dest, in1_valid, in1_data, in1_dest,
               out0_ready, out1_ready,
        input  in0_ready, in1_ready, out0_valid, out0_data, out0_dest,
               out1_valid, out1_data, out1_dest, conflict_cnt
    );

    modport slave (
        input  mode, in0_valid, in0_data, in0_dest, in1_valid, in1_data, in1_dest,
               out0_ready, out1_ready,
        output in0_ready, in1_ready, out0_valid, out0_data, out0_dest,
               out1_valid, out1_data, out1_dest, conflict_cnt
    );
endinterface

// File: rtl/banyan_fifo.sv
// banyan_fifo: per-input flit FIFO, DEPTH entries of W bits
// Ports: clk, rst_n, push/wdata (caller gates with !full), pop (caller gates with !empty), full, empty, head
module banyan_fifo
    import banyan_pkg::*;
#(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/banyan_se2x2_buf.sv
// banyan_se2x2_buf: buffered 2x2 banyan element with per-output round-robin arbitration
// Ports: clk, rst_n (sync, active-low), bus (slave side of banyan_se2x2_buf_if)
module banyan_se2x2_buf
    import banyan_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEST_W    = 2,
    parameter int ROUTE_BIT = 0,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst_n,
    banyan_se2x2_buf_if.slave bus
);
    localparam int FW = DATA_W + DEST_W;

    logic [1:0]         full, empty, push, pop, tgt, out_ready, win, gnt, con;
    logic [1:0]         req [2];
    logic [1:0][FW-1:0] head;
    logic [1:0]         out_valid_q, out_valid_d, rr_q, rr_d;
    logic [1:0][FW-1:0] out_flit_q, out_flit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign push      = {bus.in1_valid & ~full[1], bus.in0_valid & ~full[0]};
    assign out_ready = {bus.out1_ready, bus.out0_ready};

    banyan_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst_n(rst_n), .push(push[0]), .wdata({bus.in0_data, bus.in0_dest}),
        .pop(pop[0]), .full(full[0]), .empty(empty[0]), .head(head[0])
    );

    banyan_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .push(push[1]), .wdata({bus.in1_data, bus.in1_dest}),
        .pop(pop[1]), .full(full[1]), .empty(empty[1]), .head(head[1])
    );

    // head target: forced modes ignore the tag, 11 falls back to self-routing
    always_comb begin
        tgt[0] = bus.mode == MODE_CROSS ? 1'b1 : bus.mode == MODE_STRAIGHT ? 1'b0 : head[0][ROUTE_BIT];
        tgt[1] = bus.mode == MODE_CROSS ? 1'b0 : bus.mode == MODE_STRAIGHT ? 1'b1 : head[1][ROUTE_BIT];
    end

    // each free output takes one requesting head; on a tie the rr pointer picks
    // the winner and then moves to the loser
    always_comb begin
        pop = '0;
        for (int o = 0; o < 2; o++) begin
            req[o]         = {~empty[1] & (tgt[1] == o[0]), ~empty[0] & (tgt[0] == o[0])};
            gnt[o]         = (~out_valid_q[o] | out_ready[o]) & |req[o];
            con[o]         = gnt[o] & &req[o];
            win[o]         = con[o] ? rr_q[o] : req[o][1];
            rr_d[o]        = con[o] ? ~rr_q[o] : rr_q[o];
            out_valid_d[o] = (~out_valid_q[o] | out_ready[o]) ? gnt[o] : out_valid_q[o];
            out_flit_d[o]  = gnt[o] ? head[win[o]] : out_flit_q[o];
            if (gnt[o]) pop[win[o]] = 1'b1;
        end
        cnt_d = (|con && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_flit_q  <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in0_ready    = ~full[0];
    assign bus.in1_ready    = ~full[1];
    assign bus.out0_valid   = out_valid_q[0];
    assign bus.out1_valid   = out_valid_q[1];
    assign bus.out0_data    = out_flit_q[0][FW-1:DEST_W];
    assign bus.out1_data    = out_flit_q[1][FW-1:DEST_W];
    assign bus.out0_dest    = out_flit_q[0][DEST_W-1:0];
    assign bus.out1_dest    = out_flit_q[1][DEST_W-1:0];
    assign bus.conflict_cnt = cnt_q;
endmodule
